uart_rx_autobaud: RTL and testbench

//  Parametrised auto-baud serial receiver for the slave FPGA ADC links. Each micro frame is:
//   - a 0 start bit, then a 1 start bit;
//   - DATA_BITS data bits, MSB first;
//   - [parity bit];
//   - a 1 stop bit.
//  The low start bit is timed in clk cycles and sets the bit period for that frame.

---
 rtl/uart_rx_autobaud_if.sv | 27 ++
 rtl/uart_rx_autobaud.sv | 208 ++++++++++++++++++++
 tb/tb_uart_rx_autobaud.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_autobaud_if.sv
// Purpose: signal bundle for uart_rx_autobaud.
//   master : drives the serial line (Rx_data), observes the receiver results.
//   slave  : the receiver; samples Rx_data, drives rx_data, rx_valid, err,
//            err_code, bit_period, busy and estado.
interface uart_rx_autobaud_if #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned CNT_W     = 8
);
    logic                 Rx_data;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 err;
    logic [1:0]           err_code;
    logic [CNT_W-1:0]     bit_period;
    logic                 busy;
    logic [2:0]           estado;

    modport master (
        output Rx_data,
        input  rx_data, rx_valid, err, err_code, bit_period, busy, estado
    );

    modport slave (
        input  Rx_data,
        output rx_data, rx_valid, err, err_code, bit_period, busy, estado
    );
endinterface

// File: rtl/uart_rx_autobaud.sv
// Purpose: auto-baud serial receiver. Each frame is a low start bit (timed to
// get the bit period P), a high start bit, DATA_BITS data bits MSB first,
// an optional even-parity bit and a high stop bit.
// Ports:
//   clk    : system clock, posedge
//   reset  : synchronous, active-low
//   bus    : uart_rx_autobaud_if.slave
//            Rx_data in (async line), rx_data/bit_period last good word/period,
//            rx_valid/err one-cycle pulses, err_code cause of last err,
//            busy (MEASURE..DONE), estado (state code, debug)
// Optional feature: define UART_RX_PARITY_EN to add the parity bit / PAR state.
// estado codes: 0 IDLE, 1 MEASURE, 2 ALIGN, 3 DATA (and PAR), 4 STOP,
//               5 DONE, 6 ERROR, 7 SYNC.
module uart_rx_autobaud #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned MAX_LOW_CNT = 250,
    parameter int unsigned MIN_PERIOD  = 4,
    parameter int unsigned SYNC_ONES   = 50
) (
    input  logic              clk,
    input  logic              reset,
    uart_rx_autobaud_if.slave bus
);
    localparam int unsigned TICK_W = CNT_W + 1;
    localparam int unsigned NBIT_W = $clog2(DATA_BITS + 1);
    localparam int unsigned SYNC_W = $clog2(SYNC_ONES + 1);

    // Low three bits are the estado code; PAR reports as DATA.
    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        MEASURE = 4'd1,
        ALIGN   = 4'd2,
        DATA    = 4'd3,
        STOP    = 4'd4,
        DONE    = 4'd5,
        ERROR   = 4'd6,
        SYNC    = 4'd7
`ifdef UART_RX_PARITY_EN
        ,
        PAR     = 4'd11
`endif
    } state_t;

`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = PAR;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t               state;
    logic                 rx_meta;
    logic                 rx_s;
    logic [CNT_W-1:0]     meas;
    logic [CNT_W-1:0]     period;
    logic [TICK_W-1:0]    tick;
    logic [DATA_BITS-1:0] shift;
    logic [NBIT_W-1:0]    nbit;
    logic [SYNC_W-1:0]    sync_cnt;

    logic                 sample_c;
    logic                 tick_run_c;
    logic [TICK_W-1:0]    tick_reload_c;
    logic [DATA_BITS-1:0] shift_nx_c;

    // Bit-timing helpers shared by ALIGN/DATA/PAR/STOP.
    assign sample_c      = (tick == '0);
    assign tick_reload_c = TICK_W'(period) - TICK_W'(1);
    assign shift_nx_c    = (shift << 1) | DATA_BITS'(rx_s);
`ifdef UART_RX_PARITY_EN
    assign tick_run_c    = (state == ALIGN) || (state == DATA) || (state == PAR) || (state == STOP);
`else
    assign tick_run_c    = (state == ALIGN) || (state == DATA) || (state == STOP);
`endif

    assign bus.estado = state[2:0];

    // Synchroniser, frame FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta        <= 1'b1;
            rx_s           <= 1'b1;
            state          <= SYNC;
            meas           <= '0;
            period         <= '0;
            tick           <= '0;
            shift          <= '0;
            nbit           <= '0;
            sync_cnt       <= '0;
            bus.rx_data    <= '0;
            bus.rx_valid   <= 1'b0;
            bus.err        <= 1'b0;
            bus.err_code   <= '0;
            bus.bit_period <= '0;
            bus.busy       <= 1'b0;
        end else begin
            rx_meta      <= bus.Rx_data;
            rx_s         <= rx_meta;
            bus.rx_valid <= 1'b0;
            bus.err      <= 1'b0;

            if (tick_run_c) begin
                tick <= sample_c ? tick_reload_c : tick - TICK_W'(1);
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= MEASURE;
                        meas     <= CNT_W'(1);
                        bus.busy <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (!rx_s) begin
                        if (meas == CNT_W'(MAX_LOW_CNT)) begin
                            state        <= ERROR;
                            bus.err      <= 1'b1;
                            bus.err_code <= 2'd0;
                            bus.busy     <= 1'b0;
                        end else begin
                            meas <= meas + CNT_W'(1);
                        end
                    end else if (meas < CNT_W'(MIN_PERIOD)) begin
                        state        <= ERROR;
                        bus.err      <= 1'b1;
                        bus.err_code <= 2'd1;
                        bus.busy     <= 1'b0;
                    end else begin
                        // First sample lands 1.5 periods after the high start bit begins.
                        period <= meas;
                        tick   <= TICK_W'(meas) + TICK_W'(meas >> 1) - TICK_W'(1);
                        state  <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (sample_c) begin
                        shift <= shift_nx_c;
                        nbit  <= NBIT_W'(1);
                        state <= (DATA_BITS == 1) ? AFTER_DATA : DATA;
                    end
                end
                DATA: begin
                    if (sample_c) begin
                        shift <= shift_nx_c;
                        nbit  <= nbit + NBIT_W'(1);
                        if (nbit == NBIT_W'(DATA_BITS - 1)) begin
                            state <= AFTER_DATA;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PAR: begin
                    if (sample_c) begin
                        if (rx_s != (^shift)) begin
                            state        <= ERROR;
                            bus.err      <= 1'b1;
                            bus.err_code <= 2'd3;
                            bus.busy     <= 1'b0;
                        end else begin
                            state <= STOP;
                        end
                    end
                end
`endif
                STOP: begin
                    if (sample_c) begin
                        if (rx_s) begin
                            state          <= DONE;
                            bus.rx_data    <= shift;
                            bus.bit_period <= period;
                            bus.rx_valid   <= 1'b1;
                        end else begin
                            state        <= ERROR;
                            bus.err      <= 1'b1;
                            bus.err_code <= 2'd2;
                            bus.busy     <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                ERROR: begin
                    state    <= SYNC;
                    sync_cnt <= '0;
                end
                SYNC: begin
                    // Only a long enough run of idle-high cycles re-arms the receiver.
                    if (!rx_s) begin
                        sync_cnt <= '0;
                    end else if (sync_cnt == SYNC_W'(SYNC_ONES - 1)) begin
                        sync_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        sync_cnt <= sync_cnt + SYNC_W'(1);
                    end
                end
                default: begin
                    state    <= SYNC;
                    sync_cnt <= '0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_autobaud.sv
// Purpose: self-checking bench for uart_rx_autobaud. Frames are driven on the
// line in whole bit periods; a monitor records every rx_valid / err pulse and
// each scenario compares the recorded events with its own expectations.
module tb_uart_rx_autobaud;
`ifdef UART_RX_PARITY_EN
    localparam bit PARITY_ON = 1'b1;
`else
    localparam bit PARITY_ON = 1'b0;
`endif
    localparam int MAX_LOW = 250;
    localparam int MIN_P   = 4;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
        logic [7:0] aux;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   overlap_cnt = 0;
    int   code3_cnt = 0;
    logic [7:0] exp_last = 8'h00;
    ev_t  obs_q[$];
    int   obs_cyc[$];

    uart_rx_autobaud_if #(.DATA_BITS(8), .CNT_W(8)) bus ();

    uart_rx_autobaud #(
        .DATA_BITS(8), .CNT_W(8), .MAX_LOW_CNT(250), .MIN_PERIOD(4), .SYNC_ONES(50)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(input logic e, input logic [7:0] d, input logic [7:0] a);
        ev_t v;
        v.is_err = e;
        v.data   = d;
        v.aux    = a;
        return v;
    endfunction

    // Reference outcome of one frame: 0..3 error code, 4 good word.
    function automatic int frame_outcome(input int low_len, input logic stop_v, input logic par_flip);
        if (low_len > MAX_LOW) return 0;
        if (low_len < MIN_P) return 1;
        if (PARITY_ON && par_flip) return 3;
        if (!stop_v) return 2;
        return 4;
    endfunction

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (bus.rx_valid === 1'b1) begin
                obs_q.push_back(mk(1'b0, bus.rx_data, bus.bit_period));
                obs_cyc.push_back(cyc);
            end
            if (bus.err === 1'b1) begin
                obs_q.push_back(mk(1'b1, bus.rx_data, 8'(bus.err_code)));
                obs_cyc.push_back(cyc);
                if (bus.err_code == 2'd3) code3_cnt++;
            end
            if (bus.rx_valid === 1'b1 && bus.err === 1'b1) overlap_cnt++;
        end
    end

    task automatic drive(input logic v, input int n);
        bus.Rx_data = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int p, input int low_len,
                              input logic stop_v, input logic par_flip);
        drive(1'b0, low_len);
        drive(1'b1, p);
        for (int i = 7; i >= 0; i--) drive(d[i], p);
        if (PARITY_ON) drive((^d) ^ par_flip, p);
        drive(stop_v, p);
        bus.Rx_data = 1'b1;
    endtask

    task automatic clear_obs();
        obs_q.delete();
        obs_cyc.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.Rx_data = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({bus.rx_data, bus.rx_valid, bus.err, bus.err_code, bus.bit_period, bus.busy, bus.estado}
            !== {8'h00, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 3'd7}) begin
            n_fail++;
            $display("FAIL reset_outputs: got data=%h v=%b e=%b code=%0d per=%0d busy=%b st=%0d, want all 0, st=7",
                     bus.rx_data, bus.rx_valid, bus.err, bus.err_code, bus.bit_period, bus.busy, bus.estado);
        end
        reset = 1'b1;
        repeat (30) @(negedge clk);
        n_tests++;
        if (bus.estado !== 3'd7) begin
            n_fail++;
            $display("FAIL reset_still_sync: got estado=%0d want 7", bus.estado);
        end
        repeat (30) @(negedge clk);
        n_tests++;
        if (bus.estado !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_to_idle: got estado=%0d want 0", bus.estado);
        end
        exp_last = 8'h00;
    endtask

    task automatic test_basic();
        int c0;
        int lat;
        clear_obs();
        c0 = cyc;
        send_frame(8'hA5, 40, 40, 1'b1, 1'b0);
        drive(1'b1, 40);
        n_tests++;
        if (obs_q.size() != 1) begin
            n_fail++;
            $display("FAIL basic_count: got %0d events want 1", obs_q.size());
        end
        if (obs_q.size() >= 1) begin
            n_tests++;
            if (obs_q[0] !== mk(1'b0, 8'hA5, 8'd40)) begin
                n_fail++;
                $display("FAIL basic_word: got %h want %h", obs_q[0], mk(1'b0, 8'hA5, 8'd40));
            end
            lat = (10 + int'(PARITY_ON)) * 40 + 20 + 3;
            n_tests++;
            if (obs_cyc[0] - c0 < lat - 2 || obs_cyc[0] - c0 > lat + 2) begin
                n_fail++;
                $display("FAIL basic_latency: got %0d cycles want %0d +-2", obs_cyc[0] - c0, lat);
            end
        end
        exp_last = 8'hA5;
    endtask

    task automatic test_rate_change();
        ev_t exp_q[$];
        clear_obs();
        send_frame(8'h3C, 40, 40, 1'b1, 1'b0);
        drive(1'b1, 5 * 40);
        send_frame(8'hC3, 20, 20, 1'b1, 1'b0);
        drive(1'b1, 40);
        exp_q.push_back(mk(1'b0, 8'h3C, 8'd40));
        exp_q.push_back(mk(1'b0, 8'hC3, 8'd20));
        exp_last = 8'hC3;
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rate_count: got %0d events want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rate_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_framing_resync();
        ev_t exp_q[$];
        clear_obs();
        send_frame(8'h5A, 40, 40, 1'b0, 1'b0);
        drive(1'b1, 30);
        send_frame(8'h55, 40, 40, 1'b1, 1'b0);
        drive(1'b1, 60);
        send_frame(8'h96, 40, 40, 1'b1, 1'b0);
        drive(1'b1, 40);
        exp_q.push_back(mk(1'b1, exp_last, 8'd2));
        exp_q.push_back(mk(1'b0, 8'h96, 8'd40));
        exp_last = 8'h96;
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL framing_count: got %0d events want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL framing_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_tests++;
        if (bus.err_code !== 2'd2) begin
            n_fail++;
            $display("FAIL framing_code_hold: got %0d want 2", bus.err_code);
        end
    endtask

    task automatic test_timeout();
        ev_t exp_q[$];
        int  c0;
        clear_obs();
        c0 = cyc;
        drive(1'b0, 300);
        drive(1'b1, 60);
        send_frame(8'h42, 40, 40, 1'b1, 1'b0);
        drive(1'b1, 40);
        exp_q.push_back(mk(1'b1, exp_last, 8'd0));
        exp_q.push_back(mk(1'b0, 8'h42, 8'd40));
        exp_last = 8'h42;
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL timeout_count: got %0d events want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL timeout_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        if (obs_cyc.size() >= 1) begin
            n_tests++;
            if (obs_cyc[0] - c0 < 251 || obs_cyc[0] - c0 > 255) begin
                n_fail++;
                $display("FAIL timeout_when: got err %0d cycles after line low, want 253 +-2", obs_cyc[0] - c0);
            end
        end
    endtask

    task automatic test_short_and_min();
        ev_t exp_q[$];
        int  l;
        clear_obs();
        l = $urandom_range(1, 3);
        drive(1'b0, l);
        drive(1'b1, 80);
        send_frame(8'h69, 4, 4, 1'b1, 1'b0);
        drive(1'b1, 20);
        exp_q.push_back(mk(1'b1, exp_last, 8'(frame_outcome(l, 1'b1, 1'b0))));
        exp_q.push_back(mk(1'b0, 8'h69, 8'd4));
        exp_last = 8'h69;
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL short_count: got %0d events want %0d (low=%0d)", obs_q.size(), exp_q.size(), l);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL short_ev%0d: got %h want %h (low=%0d)", i, obs_q[i], exp_q[i], l);
            end
        end
    endtask

    task automatic test_long_boundary();
        ev_t exp_q[$];
        clear_obs();
        send_frame(8'hB4, 250, 250, 1'b1, 1'b0);
        drive(1'b1, 250);
        drive(1'b0, 251);
        drive(1'b1, 80);
        exp_q.push_back(mk(1'b0, 8'hB4, 8'd250));
        exp_q.push_back(mk(1'b1, 8'hB4, 8'd0));
        exp_last = 8'hB4;
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL long_count: got %0d events want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL long_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_tests++;
        if (bus.bit_period !== 8'd250) begin
            n_fail++;
            $display("FAIL long_period_hold: got %0d want 250", bus.bit_period);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        clear_obs();
        send_frame(8'h7E, 40, 40, 1'b1, 1'b0);
        drive(1'b1, 40);
        d = 8'hF0;
        drive(1'b0, 40);
        drive(1'b1, 40);
        for (int i = 7; i >= 4; i--) drive(d[i], 40);
        drive(d[3], 20);
        n_tests++;
        if ({bus.busy, bus.estado} !== {1'b1, 3'd3}) begin
            n_fail++;
            $display("FAIL midframe_in_data: got busy=%b estado=%0d want busy=1 estado=3", bus.busy, bus.estado);
        end
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({bus.rx_data, bus.rx_valid, bus.err, bus.err_code, bus.bit_period, bus.busy, bus.estado}
            !== {8'h00, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 3'd7}) begin
            n_fail++;
            $display("FAIL midframe_reset: got data=%h v=%b e=%b code=%0d per=%0d busy=%b st=%0d, want all 0, st=7",
                     bus.rx_data, bus.rx_valid, bus.err, bus.err_code, bus.bit_period, bus.busy, bus.estado);
        end
        reset = 1'b1;
        drive(1'b1, 100);
        n_tests++;
        if (obs_q.size() != 1) begin
            n_fail++;
            $display("FAIL midframe_count: got %0d events want 1", obs_q.size());
        end
        if (obs_q.size() >= 1) begin
            n_tests++;
            if (obs_q[0] !== mk(1'b0, 8'h7E, 8'd40)) begin
                n_fail++;
                $display("FAIL midframe_first: got %h want %h", obs_q[0], mk(1'b0, 8'h7E, 8'd40));
            end
        end
        exp_last = 8'h00;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        ev_t exp_q[$];
        clear_obs();
        send_frame(8'h81, 40, 40, 1'b1, 1'b1);
        drive(1'b1, 60);
        send_frame(8'h81, 40, 40, 1'b1, 1'b0);
        drive(1'b1, 40);
        exp_q.push_back(mk(1'b1, exp_last, 8'd3));
        exp_q.push_back(mk(1'b0, 8'h81, 8'd40));
        exp_last = 8'h81;
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL parity_count: got %0d events want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL parity_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask
`endif

    task automatic test_random();
        ev_t        exp_q[$];
        logic [7:0] d;
        logic       stop_v;
        logic       par_flip;
        int         p;
        int         out;
        clear_obs();
        for (int k = 0; k < 12; k++) begin
            p        = $urandom_range(MIN_P, 60);
            d        = 8'($urandom);
            stop_v   = ($urandom_range(0, 4) != 0);
            par_flip = PARITY_ON && ($urandom_range(0, 4) == 0);
            out      = frame_outcome(p, stop_v, par_flip);
            send_frame(d, p, p, stop_v, par_flip);
            if (out == 4) begin
                exp_q.push_back(mk(1'b0, d, 8'(p)));
                exp_last = d;
                drive(1'b1, $urandom_range(1, 2 * p));
            end else begin
                exp_q.push_back(mk(1'b1, exp_last, 8'(out)));
                drive(1'b1, 60 + $urandom_range(0, p));
            end
        end
        drive(1'b1, 40);
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL random_count: got %0d events want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL random_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_pulse_rules();
        n_tests++;
        if (overlap_cnt != 0) begin
            n_fail++;
            $display("FAIL pulse_overlap: got %0d cycles with rx_valid and err both high, want 0", overlap_cnt);
        end
`ifndef UART_RX_PARITY_EN
        n_tests++;
        if (code3_cnt != 0) begin
            n_fail++;
            $display("FAIL no_code3: got %0d err pulses with code 3, want 0", code3_cnt);
        end
`endif
    endtask

    initial begin
        reset = 1'b0;
        bus.Rx_data = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_rate_change();
        test_framing_resync();
        test_timeout();
        test_short_and_min();
        test_long_boundary();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        test_pulse_rules();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
